datapath_ctrl: RTL

Multicycle instruction sequencer that drives the `datapath` block. It fetches 16-bit instruction words from instruction memory over a req/ack handshake and holds the program counter. It presents each word to the datapath as `Opcode`, with a one-cycle register write strobe, and latches the returned ALU flags into a processor status register (PSR). The PSR supplies `Cin` and resolves conditional branches.

---
 rtl/datapath_pkg.sv | 38 +++
 rtl/cond_eval.sv | 31 +++
 rtl/datapath_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/datapath_pkg.sv
// Shared definitions for the datapath sequencer: FSM states, PSR flag positions, decode constants.
// Latency: none (package only).
// Backpressure: not applicable.
package datapath_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  // Bit positions inside the 5-bit flag / PSR vector {C, L, F, Z, N}
  localparam int FLAG_C = 4;
  localparam int FLAG_L = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  localparam logic [3:0]  OP_BCOND   = 4'hC;
  localparam logic [15:0] INSTR_HALT = 16'hFFFF;

  // Branch condition codes carried in IR[11:8]
  localparam logic [3:0] CC_EQ = 4'h0;
  localparam logic [3:0] CC_NE = 4'h1;
  localparam logic [3:0] CC_CS = 4'h2;
  localparam logic [3:0] CC_CC = 4'h3;
  localparam logic [3:0] CC_FS = 4'h4;
  localparam logic [3:0] CC_FC = 4'h5;
  localparam logic [3:0] CC_LO = 4'h6;
  localparam logic [3:0] CC_HS = 4'h7;
  localparam logic [3:0] CC_AL = 4'hE;

  function automatic logic is_bcond(input logic [15:0] ir);
    return (ir[15:12] == OP_BCOND);
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Branch condition evaluator: decides whether a Bcond is taken from the PSR and IR[11:8].
// Latency: purely combinational, zero cycles.
// Backpressure: none. Only built when DATAPATH_CTRL_BRANCH_EN is defined.
`ifdef DATAPATH_CTRL_BRANCH_EN
module cond_eval
  import datapath_pkg::*;
(
  input  logic [FLAG_C:FLAG_Z] psr,   // N never participates in a branch condition
  input  logic [3:0]           cc,
  output logic                 taken
);

  // Map each condition code onto its PSR test; unassigned codes never branch
  always_comb begin
    taken = 1'b0;
    case (cc)
      CC_EQ:   taken =  psr[FLAG_Z];
      CC_NE:   taken = !psr[FLAG_Z];
      CC_CS:   taken =  psr[FLAG_C];
      CC_CC:   taken = !psr[FLAG_C];
      CC_FS:   taken =  psr[FLAG_F];
      CC_FC:   taken = !psr[FLAG_F];
      CC_LO:   taken =  psr[FLAG_L];
      CC_HS:   taken = !psr[FLAG_L];
      CC_AL:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule
`endif

// File: rtl/datapath_ctrl.sv
// Multicycle sequencer: fetches 16-bit words over req/ack, drives Opcode/RegWrEn, latches flags into the PSR.
// Latency: one instruction per 1 + N cycles (N fetch cycles including the ack cycle, N >= 1).
// Backpressure: MemReq/MemAddr are held until MemAck; DATAPATH_CTRL_BRANCH_EN enables Bcond (else Bcond is a NOP).
module datapath_ctrl
  import datapath_pkg::*;
#(
  parameter int                  PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                Clk,
  input  logic                Reset,
  output logic                MemReq,
  output logic [PC_WIDTH-1:0] MemAddr,
  input  logic                MemAck,
  input  logic [15:0]         MemData,
  output logic [15:0]         Opcode,
  output logic                RegWrEn,
  output logic                Cin,
  input  logic [4:0]          Flags,
  output logic [4:0]          Psr,
  output logic                Halted
);

  state_t              state;
  state_t              state_nxt;
  logic [PC_WIDTH-1:0] pc;
  logic [15:0]         ir;
  logic [4:0]          psr;

  logic                is_halt;
  logic                is_br;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] pc_exec;

  assign is_halt = (ir == INSTR_HALT);
  assign is_br   = is_bcond(ir) && !is_halt;
  assign pc_inc  = pc + PC_WIDTH'(1);

`ifdef DATAPATH_CTRL_BRANCH_EN
  logic                br_taken;
  logic [PC_WIDTH-1:0] disp_ext;

  cond_eval u_cond_eval (
    .psr   (psr[FLAG_C:FLAG_Z]),
    .cc    (ir[11:8]),
    .taken (br_taken)
  );

  assign disp_ext = {{(PC_WIDTH-8){ir[7]}}, ir[7:0]};
  assign pc_exec  = (is_br && br_taken) ? (pc + disp_ext) : pc_inc;
`else
  // Bcond falls through as a NOP, so every non-halt instruction just advances
  assign pc_exec = pc_inc;
`endif

  // State register; reset parks the FSM in IDLE, which also drops MemReq immediately
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: one IDLE cycle, fetch until ack, one execute cycle, HALT is terminal
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  state_nxt = ST_FETCH;
      ST_FETCH: if (MemAck) state_nxt = ST_EXEC;
      ST_EXEC:  state_nxt = is_halt ? ST_HALT : ST_FETCH;
      ST_HALT:  state_nxt = ST_HALT;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Moore outputs decoded from the current state (and the held IR in EXEC)
  always_comb begin
    MemReq  = 1'b0;
    RegWrEn = 1'b0;
    Halted  = 1'b0;
    case (state)
      ST_FETCH: MemReq  = 1'b1;
      ST_EXEC:  RegWrEn = !is_halt && !is_br;
      ST_HALT:  Halted  = 1'b1;
      default:  ;
    endcase
  end

  // IR loads on the ack edge; PC and PSR only move on the edge leaving EXEC
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pc  <= RESET_PC;
      ir  <= 16'h0000;
      psr <= 5'b0;
    end else begin
      if (state == ST_FETCH && MemAck) begin
        ir <= MemData;
      end
      if (state == ST_EXEC && !is_halt) begin
        pc <= pc_exec;
        if (!is_br) begin
          psr <= Flags;
        end
      end
    end
  end

  assign MemAddr = pc;
  assign Opcode  = ir;
  assign Psr     = psr;
  assign Cin     = psr[FLAG_C];

endmodule
